// File: rtl/lm07_read_scheduler_if.sv
// Sensor pins plus result/handshake/alert signals of the LM07 read scheduler.
// master: the surrounding logic and sensor; slave: the scheduler itself.
interface lm07_read_scheduler_if #(
  parameter int unsigned NBITS = 16
) ();

  logic             en;
  logic             start;
  logic             cont;
  logic             sio;
  logic             cs;
  logic             sck;
  logic             busy;
  logic [NBITS-1:0] temp_data;
  logic [8:0]       temp_deg;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;
  logic [8:0]       thr_hi;
  logic [8:0]       thr_lo;
  logic             alert;

  modport master (
    output en, start, cont, sio, data_ready, thr_hi, thr_lo,
    input  cs, sck, busy, temp_data, temp_deg, data_valid, overrun, alert
  );

  modport slave (
    input  en, start, cont, sio, data_ready, thr_hi, thr_lo,
    output cs, sck, busy, temp_data, temp_deg, data_valid, overrun, alert
  );

endinterface

// File: rtl/lm07_read_scheduler.sv
// LM07/LM70 three-wire SPI read scheduler: one-shot or periodic 16-bit reads,
// result held behind a valid/ready handshake with a sticky overrun flag.
// Optional over-temperature alert with hysteresis: define LM07_ALERT_EN.
module lm07_read_scheduler #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned PERIOD  = 200,
  parameter int unsigned NBITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  lm07_read_scheduler_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(NBITS + 1);
  localparam int unsigned PER_W = $clog2(PERIOD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             phase_q, phase_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] temp_data_q, temp_data_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic [PER_W-1:0] per_q, per_d;

  logic             div_last_c;
  logic             start_xfer_c;
  logic             load_c;

  // Transfer sequencer: SETUP, NBITS low/high SCK phases, HOLD, back to IDLE
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    cs_d         = cs_q;
    sck_d        = sck_q;
    start_xfer_c = 1'b0;
    load_c       = 1'b0;
    div_last_c   = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      ST_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (bus.en && (bus.start || (bus.cont && (per_q == '0)))) begin
          state_d      = ST_SETUP;
          cs_d         = 1'b0;
          div_d        = '0;
          bit_d        = '0;
          phase_d      = 1'b0;
          start_xfer_c = 1'b1;
        end
      end

      ST_SETUP: begin
        if (div_last_c) begin
          state_d = ST_SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_SHIFT: begin
        if (!div_last_c) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // sio has been stable for the whole low phase; sample on the rising SCK
            sck_d   = 1'b1;
            shift_d = {shift_q[NBITS-2:0], bus.sio};
            phase_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            phase_d = 1'b0;
            if (bit_q == BIT_W'(NBITS - 1)) begin
              state_d = ST_HOLD;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
      end

      ST_HOLD: begin
        sck_d = 1'b0;
        if (div_last_c) begin
          state_d = ST_IDLE;
          div_d   = '0;
          cs_d    = 1'b1;
          load_c  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Result register and valid/ready handshake; a load beats a same-edge accept
  always_comb begin
    temp_data_d  = temp_data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;

    if (data_valid_q && bus.data_ready) begin
      data_valid_d = 1'b0;
    end

    if (load_c) begin
      temp_data_d  = shift_q;
      data_valid_d = 1'b1;
      if (data_valid_q && !bus.data_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Period counter: reload at each start, count down to zero, cleared while disabled
  always_comb begin
    per_d = per_q;
    if (!bus.en) begin
      per_d = '0;
    end else if (start_xfer_c) begin
      per_d = PER_W'(PERIOD - 1);
    end else if (per_q != '0) begin
      per_d = per_q - PER_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      shift_q      <= '0;
      cs_q         <= 1'b1;
      sck_q        <= 1'b0;
      busy_q       <= 1'b0;
      temp_data_q  <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      per_q        <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      cs_q         <= cs_d;
      sck_q        <= sck_d;
      busy_q       <= busy_d;
      temp_data_q  <= temp_data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      per_q        <= per_d;
    end
  end

`ifdef LM07_ALERT_EN
  logic             alert_q, alert_d;
  logic signed [8:0] new_deg_c;

  // Hysteretic alert evaluated on each new result; set wins over clear
  always_comb begin
    new_deg_c = $signed(shift_q[NBITS-1 -: 9]);
    alert_d   = alert_q;
    if (load_c) begin
      if (new_deg_c >= $signed(bus.thr_hi)) begin
        alert_d = 1'b1;
      end else if (new_deg_c <= $signed(bus.thr_lo)) begin
        alert_d = 1'b0;
      end
    end
  end

  // Alert register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alert_q <= 1'b0;
    end else begin
      alert_q <= alert_d;
    end
  end

  assign bus.alert = alert_q;
`else
  logic unused_thr_c;
  assign unused_thr_c = ^{bus.thr_hi, bus.thr_lo};
  assign bus.alert    = 1'b0;
`endif

  assign bus.cs         = cs_q;
  assign bus.sck        = sck_q;
  assign bus.busy       = busy_q;
  assign bus.temp_data  = temp_data_q;
  assign bus.temp_deg   = temp_data_q[NBITS-1 -: 9];
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;

endmodule
